add_order_writer: RTL and testbench

- Write-side companion to the volume-at-limit query logic.
- Inserts one new order into the buy or sell order-book RAM at the first empty slot (entry == 48'b0).
- Keeps each book contiguous from address 0, so scanning readers stop correctly at the first zero entry.
- Owns the RAM address/write port during an operation; uses a start/done handshake identical to the other book command blocks.

---
 rtl/add_order_writer.sv | 170 +++++++++++++++++
 tb/tb_add_order_writer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_order_writer.sv
// Appends one order at the first empty buy/sell slot; insert done 2N+4 edges after start, full 2*MAX+1, reject 2.
// Holds done until start drops (start/done handshake); `define AGGREGATE_EN merges into a same-price entry.
module add_order_writer #(
  parameter int MAX_BOOK_SIZE = 10,
  parameter int ADDR_W        = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_side,
  input  logic [15:0]       i_limit,
  input  logic [15:0]       i_volume,
  input  logic [15:0]       i_order_id,
  input  logic [47:0]       i_buy_rdata,
  input  logic [47:0]       i_sell_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [47:0]       o_ram_wdata,
  output logic              o_buy_wren,
  output logic              o_sell_wren,
  output logic [ADDR_W-1:0] o_slot,
  output logic [1:0]        o_status,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] ST_INSERTED = 2'b00;
  localparam logic [1:0] ST_FULL     = 2'b01;
  localparam logic [1:0] ST_REJECTED = 2'b10;
  localparam logic [1:0] ST_MERGED   = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(MAX_BOOK_SIZE - 1);

  logic [2:0]        r_state;
  logic              r_side;
  logic [15:0]       r_limit;
  logic [15:0]       r_volume;
  logic [15:0]       r_order_id;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [47:0]       r_ram_wdata;
  logic              r_buy_wren;
  logic              r_sell_wren;
  logic [ADDR_W-1:0] r_slot;
  logic [1:0]        r_status;
  logic              r_done;

  logic [47:0] w_rdata;
  logic [47:0] w_new_wdata;
  logic [47:0] w_merge_wdata;
  logic        w_match;

  assign w_rdata     = r_side ? i_sell_rdata : i_buy_rdata;
  assign w_new_wdata = {r_order_id, r_volume, r_limit};

`ifdef AGGREGATE_EN
  logic [16:0] w_sum;
  assign w_sum         = {1'b0, w_rdata[31:16]} + {1'b0, r_volume};
  assign w_match       = (w_rdata != 48'd0) && (w_rdata[15:0] == r_limit);
  assign w_merge_wdata = {w_rdata[47:32], (w_sum[16] ? 16'hFFFF : w_sum[15:0]), r_limit};
`else
  assign w_match       = 1'b0;
  assign w_merge_wdata = w_new_wdata;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_side      <= 1'b0;
      r_limit     <= 16'd0;
      r_volume    <= 16'd0;
      r_order_id  <= 16'd0;
      r_ptr       <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 48'd0;
      r_buy_wren  <= 1'b0;
      r_sell_wren <= 1'b0;
      r_slot      <= '0;
      r_status    <= 2'b00;
      r_done      <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses raised only on the CHECK->WRITE step.
      r_buy_wren  <= 1'b0;
      r_sell_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_side     <= i_side;
          r_limit    <= i_limit;
          r_volume   <= i_volume;
          r_order_id <= i_order_id;
          r_ptr      <= '0;
          r_ram_addr <= '0;
          r_slot     <= '0;
          // A zero field would make the stored entry indistinguishable from an empty slot.
          if (i_volume == 16'd0 || i_limit == 16'd0) begin
            r_status <= ST_REJECTED;
            r_state  <= S_DONE;
          end else begin
            r_status <= ST_INSERTED;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_rdata == 48'd0) begin
            r_ram_wdata <= w_new_wdata;
            r_buy_wren  <= ~r_side;
            r_sell_wren <= r_side;
            r_status    <= ST_INSERTED;
            r_state     <= S_WRITE;
          end else if (w_match) begin
            r_ram_wdata <= w_merge_wdata;
            r_buy_wren  <= ~r_side;
            r_sell_wren <= r_side;
            r_status    <= ST_MERGED;
            r_state     <= S_WRITE;
          end else if (r_ptr == LAST_SLOT) begin
            r_status <= ST_FULL;
            r_slot   <= '0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_ptr      <= r_ptr + 1'b1;
            r_ram_addr <= r_ptr + 1'b1;
            r_state    <= S_READ;
          end
        end
        S_WRITE: begin
          r_slot  <= r_ptr;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // The reject path arrives with done still low; raise it before honouring a start drop.
          if (!r_done) begin
            r_done <= 1'b1;
          end else if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_buy_wren  = r_buy_wren;
  assign o_sell_wren = r_sell_wren;
  assign o_slot      = r_slot;
  assign o_status    = r_status;
  assign o_done      = r_done;

endmodule

// File: tb/tb_add_order_writer.sv
// Bench for add_order_writer: behavioural RAMs plus a slot-scan reference model, directed and random commands.
module tb_add_order_writer;
  localparam int M      = 10;
  localparam int ADDR_W = 12;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_side = 1'b0;
  logic [15:0]       i_limit = 16'd0;
  logic [15:0]       i_volume = 16'd0;
  logic [15:0]       i_order_id = 16'd0;
  logic [47:0]       buy_rdata = 48'd0;
  logic [47:0]       sell_rdata = 48'd0;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [47:0]       o_ram_wdata;
  logic              o_buy_wren;
  logic              o_sell_wren;
  logic [ADDR_W-1:0] o_slot;
  logic [1:0]        o_status;
  logic              o_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] mem [2][16];
  logic [47:0] mdl [2][16];
  int          n_wr_buy, n_wr_sell;
  logic [ADDR_W-1:0] wr_addr;
  logic [47:0]       wr_data;

  int          obs_edge;
  logic [1:0]  obs_status;
  logic [ADDR_W-1:0] obs_slot;
  logic        obs_held, obs_after;

  add_order_writer #(.MAX_BOOK_SIZE(M), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_side(i_side),
    .i_limit(i_limit), .i_volume(i_volume), .i_order_id(i_order_id),
    .i_buy_rdata(buy_rdata), .i_sell_rdata(sell_rdata),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .o_buy_wren(o_buy_wren), .o_sell_wren(o_sell_wren),
    .o_slot(o_slot), .o_status(o_status), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAMs: one-cycle read latency, write on the wren edge.
  always @(posedge clk) begin
    if (o_buy_wren)  mem[0][o_ram_addr[3:0]] <= o_ram_wdata;
    if (o_sell_wren) mem[1][o_ram_addr[3:0]] <= o_ram_wdata;
    buy_rdata  <= mem[0][o_ram_addr[3:0]];
    sell_rdata <= mem[1][o_ram_addr[3:0]];
  end

  always @(negedge clk) begin
    if (o_buy_wren) begin
      n_wr_buy++; wr_addr = o_ram_addr; wr_data = o_ram_wdata;
    end
    if (o_sell_wren) begin
      n_wr_sell++; wr_addr = o_ram_addr; wr_data = o_ram_wdata;
    end
  end

  task automatic clear_books();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) begin
        mem[s][i] = 48'd0; mdl[s][i] = 48'd0;
      end
  endtask

  task automatic put_entry(input int s, input int i, input logic [47:0] e);
    mem[s][i] = e; mdl[s][i] = e;
  endtask

  task automatic fill(input int s, input int n);
    for (int i = 0; i < n; i++)
      put_entry(s, i, {16'(i + 1), 16'(i + 10), 16'(1000 + i)});
  endtask

  // Reference: first empty slot (or first equal price when merging) decides result and latency.
  task automatic model_cmd(input int s, input logic [15:0] lim, input logic [15:0] vol,
                           input logic [15:0] id, output logic [1:0] st, output int slot,
                           output int edge_n, output bit wr, output logic [47:0] wd);
    logic [47:0] ent;
    int sum;
    st = 2'b10; slot = 0; edge_n = 2; wr = 1'b0; wd = 48'd0;
    if (vol == 16'd0 || lim == 16'd0) return;
    st = 2'b01; edge_n = 2 * M + 1;
    for (int i = 0; i < M; i++) begin
      ent = mdl[s][i];
      if (ent == 48'd0) begin
        st = 2'b00; slot = i; wr = 1'b1; wd = {id, vol, lim}; edge_n = 2 * i + 4;
        break;
      end
`ifdef AGGREGATE_EN
      if (ent[15:0] == lim) begin
        sum = int'(ent[31:16]) + int'(vol);
        st = 2'b11; slot = i; wr = 1'b1; edge_n = 2 * i + 4;
        wd = {ent[47:32], (sum > 65535) ? 16'hFFFF : 16'(sum), lim};
        break;
      end
`endif
    end
    if (wr) mdl[s][slot] = wd;
  endtask

  task automatic run_cmd(input bit s, input logic [15:0] lim, input logic [15:0] vol,
                         input logic [15:0] id);
    int e;
    n_wr_buy = 0; n_wr_sell = 0; wr_addr = '0; wr_data = 48'd0;
    @(negedge clk);
    i_side = s; i_limit = lim; i_volume = vol; i_order_id = id; i_start = 1'b1;
    @(posedge clk); #1;
    e = 0;
    while (o_done !== 1'b1 && e < BUDGET) begin
      @(posedge clk); #1;
      e++;
      if (e == 1) begin
        // After capture these must have no effect.
        i_side = ~s; i_limit = 16'($urandom); i_volume = 16'($urandom); i_order_id = 16'($urandom);
      end
    end
    obs_edge   = (o_done === 1'b1) ? e : -1;
    obs_status = o_status;
    obs_slot   = o_slot;
    repeat (2) @(posedge clk);
    #1 obs_held = o_done;
    @(negedge clk) i_start = 1'b0;
    @(posedge clk);
    #1 obs_after = o_done;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({o_done, o_buy_wren, o_sell_wren, o_status} !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {o_done, o_buy_wren, o_sell_wren, o_status});
    end
    n_tests++;
    if (o_ram_addr !== '0 || o_slot !== '0 || o_ram_wdata !== 48'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%0h slot=%0h wdata=%0h expected 0", o_ram_addr, o_slot, o_ram_wdata);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (o_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_done: got %b expected 0", o_done);
    end
  endtask

  task automatic test_insert_empty();
    clear_books();
    run_cmd(1'b0, 16'd100, 16'd5, 16'd7);
    n_tests++;
    if (obs_edge !== 4) begin n_fail++; $display("FAIL empty_latency: got %0d expected 4", obs_edge); end
    n_tests++;
    if (n_wr_buy !== 1 || n_wr_sell !== 0) begin
      n_fail++; $display("FAIL empty_wren: buy=%0d sell=%0d expected 1/0", n_wr_buy, n_wr_sell);
    end
    n_tests++;
    if (wr_addr !== '0 || wr_data !== 48'h0007_0005_0064) begin
      n_fail++; $display("FAIL empty_write: addr=%0d data=%h expected 0/000700050064", wr_addr, wr_data);
    end
    n_tests++;
    if (obs_status !== 2'b00 || obs_slot !== '0) begin
      n_fail++; $display("FAIL empty_result: status=%b slot=%0d expected 00/0", obs_status, obs_slot);
    end
  endtask

  task automatic test_insert_sell3();
    clear_books();
    fill(1, 3);
    run_cmd(1'b1, 16'd200, 16'd3, 16'd42);
    n_tests++;
    if (obs_edge !== 10) begin n_fail++; $display("FAIL sell3_latency: got %0d expected 10", obs_edge); end
    n_tests++;
    if (n_wr_sell !== 1 || n_wr_buy !== 0 || wr_addr !== 12'd3 || wr_data !== {16'd42, 16'd3, 16'd200}) begin
      n_fail++; $display("FAIL sell3_write: sell=%0d buy=%0d addr=%0d data=%h", n_wr_sell, n_wr_buy, wr_addr, wr_data);
    end
    n_tests++;
    if (obs_status !== 2'b00 || obs_slot !== 12'd3) begin
      n_fail++; $display("FAIL sell3_result: status=%b slot=%0d expected 00/3", obs_status, obs_slot);
    end
  endtask

  task automatic test_full();
    clear_books();
    fill(0, M);
    run_cmd(1'b0, 16'd55, 16'd9, 16'd1);
    n_tests++;
    if (obs_edge !== 2 * M + 1) begin n_fail++; $display("FAIL full_latency: got %0d expected %0d", obs_edge, 2 * M + 1); end
    n_tests++;
    if (n_wr_buy !== 0 || n_wr_sell !== 0) begin
      n_fail++; $display("FAIL full_wren: buy=%0d sell=%0d expected 0/0", n_wr_buy, n_wr_sell);
    end
    n_tests++;
    if (obs_status !== 2'b01 || obs_slot !== '0) begin
      n_fail++; $display("FAIL full_result: status=%b slot=%0d expected 01/0", obs_status, obs_slot);
    end
    n_tests++;
    if (obs_held !== 1'b1 || obs_after !== 1'b0) begin
      n_fail++; $display("FAIL full_handshake: held=%b after_drop=%b expected 1/0", obs_held, obs_after);
    end
  endtask

  task automatic test_reject();
    clear_books();
    run_cmd(1'b0, 16'd300, 16'd0, 16'd5);
    n_tests++;
    if (obs_edge !== 2 || obs_status !== 2'b10) begin
      n_fail++; $display("FAIL reject_vol: edge=%0d status=%b expected 2/10", obs_edge, obs_status);
    end
    n_tests++;
    if (n_wr_buy + n_wr_sell !== 0) begin n_fail++; $display("FAIL reject_wren: got %0d writes expected 0", n_wr_buy + n_wr_sell); end
    run_cmd(1'b1, 16'd0, 16'd8, 16'd5);
    n_tests++;
    if (obs_edge !== 2 || obs_status !== 2'b10 || n_wr_sell !== 0) begin
      n_fail++; $display("FAIL reject_lim: edge=%0d status=%b writes=%0d expected 2/10/0", obs_edge, obs_status, n_wr_sell);
    end
  endtask

  task automatic test_reset_mid();
    clear_books();
    fill(0, 5);
    n_wr_buy = 0; n_wr_sell = 0;
    @(negedge clk);
    i_side = 1'b0; i_limit = 16'd77; i_volume = 16'd4; i_order_id = 16'd3; i_start = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (o_ram_addr !== 12'd2) begin n_fail++; $display("FAIL midrst_addr: got %0d expected 2", o_ram_addr); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_done, o_buy_wren, o_sell_wren, o_status} !== 5'd0 || o_ram_addr !== '0 || o_slot !== '0 || o_ram_wdata !== 48'd0) begin
      n_fail++; $display("FAIL midrst_outputs: done=%b wren=%b%b status=%b addr=%0d expected all 0",
                         o_done, o_buy_wren, o_sell_wren, o_status, o_ram_addr);
    end
    @(negedge clk) i_start = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (n_wr_buy + n_wr_sell !== 0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_nowrite: writes=%0d done=%b expected 0/0", n_wr_buy + n_wr_sell, o_done);
    end
    run_cmd(1'b0, 16'd77, 16'd4, 16'd3);
    n_tests++;
    if (obs_edge !== 14 || obs_status !== 2'b00 || obs_slot !== 12'd5 || wr_data !== {16'd3, 16'd4, 16'd77}) begin
      n_fail++; $display("FAIL midrst_after: edge=%0d status=%b slot=%0d data=%h expected 14/00/5", obs_edge, obs_status, obs_slot, wr_data);
    end
  endtask

  task automatic test_equal_price();
    clear_books();
    put_entry(0, 0, 48'd0);
    put_entry(0, 1, {16'd9, 16'hFFF0, 16'd150});
    put_entry(0, 0, {16'd4, 16'd20, 16'd140});
    run_cmd(1'b0, 16'd150, 16'd32, 16'd11);
`ifdef AGGREGATE_EN
    n_tests++;
    if (obs_status !== 2'b11 || obs_slot !== 12'd1 || obs_edge !== 6) begin
      n_fail++; $display("FAIL merge_result: status=%b slot=%0d edge=%0d expected 11/1/6", obs_status, obs_slot, obs_edge);
    end
    n_tests++;
    if (n_wr_buy !== 1 || wr_addr !== 12'd1 || wr_data !== {16'd9, 16'hFFFF, 16'd150}) begin
      n_fail++; $display("FAIL merge_write: n=%0d addr=%0d data=%h expected 1/1/0009ffff0096", n_wr_buy, wr_addr, wr_data);
    end
`else
    n_tests++;
    if (obs_status !== 2'b00 || obs_slot !== 12'd2 || obs_edge !== 8) begin
      n_fail++; $display("FAIL noagg_result: status=%b slot=%0d edge=%0d expected 00/2/8", obs_status, obs_slot, obs_edge);
    end
    n_tests++;
    if (n_wr_buy !== 1 || wr_addr !== 12'd2 || wr_data !== {16'd11, 16'd32, 16'd150}) begin
      n_fail++; $display("FAIL noagg_write: n=%0d addr=%0d data=%h", n_wr_buy, wr_addr, wr_data);
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0] st;
    int slot, edge_n;
    bit wr;
    logic [47:0] wd;
    bit s;
    logic [15:0] lim, vol, id;
    clear_books();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0) clear_books();
      s   = 1'($urandom_range(0, 1));
      lim = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'(100 + $urandom_range(0, 3));
      vol = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      id  = 16'($urandom);
      model_cmd(int'(s), lim, vol, id, st, slot, edge_n, wr, wd);
      run_cmd(s, lim, vol, id);
      n_tests++;
      if (obs_edge !== edge_n || obs_status !== st || obs_slot !== ADDR_W'(slot)) begin
        n_fail++; $display("FAIL rand%0d_result: edge=%0d status=%b slot=%0d expected %0d/%b/%0d",
                           k, obs_edge, obs_status, obs_slot, edge_n, st, slot);
      end
      n_tests++;
      if (n_wr_buy !== ((wr && !s) ? 1 : 0) || n_wr_sell !== ((wr && s) ? 1 : 0)) begin
        n_fail++; $display("FAIL rand%0d_wren: buy=%0d sell=%0d expected wr=%0d side=%0d", k, n_wr_buy, n_wr_sell, wr, s);
      end
      if (wr) begin
        n_tests++;
        if (wr_addr !== ADDR_W'(slot) || wr_data !== wd) begin
          n_fail++; $display("FAIL rand%0d_write: addr=%0d data=%h expected %0d/%h", k, wr_addr, wr_data, slot, wd);
        end
      end
      n_tests++;
      if (obs_held !== 1'b1 || obs_after !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_handshake: held=%b after=%b expected 1/0", k, obs_held, obs_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_insert_empty();
    test_insert_sell3();
    test_full();
    test_reject();
    test_reset_mid();
    test_equal_price();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
